// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over a req/ready handshake, presents the decoded
// instruction to the control unit and steps the PC on exec_done (traps on misalignment).
module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   input  logic            pc_src,
   input  logic [XLEN-1:0] imm_ext,
   input  logic            exec_done,
   output logic [31:0]     instr,
   output logic            instr_valid,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic            funct7_5,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic [31:0]     retire_count,
   output logic            misalign_err
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      TRAP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            load_instr;
   logic            commit;
   logic            trap;
   logic [XLEN-1:0] pc_target;
   logic            target_misaligned;

   // Next-PC selection; only consumed on the EXEC cycle that sees exec_done.
   assign pc_plus4          = pc + XLEN'(4);
   assign pc_target         = pc_src ? (pc + imm_ext) : pc_plus4;
   assign target_misaligned = |pc_target[1:0];

   assign imem_addr = pc;
   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7_5  = instr[30];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      load_instr  = 1'b0;
      commit      = 1'b0;
      trap        = 1'b0;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               load_instr = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (exec_done) begin
               if (target_misaligned) begin
                  trap       = 1'b1;
                  state_next = TRAP;
               end else begin
                  commit     = 1'b1;
                  state_next = FETCH;
               end
            end
         end
         TRAP: begin
            state_next = TRAP;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Architectural state: a trap leaves pc and retire_count untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         instr        <= NOP_INSTR;
         retire_count <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         if (load_instr) begin
            instr <= imem_rdata;
         end
         if (commit) begin
            pc           <= pc_target;
            retire_count <= retire_count + 32'd1;
         end
         if (trap) begin
            misalign_err <= 1'b1;
         end
      end
   end

endmodule
